// File: rtl/disp_src_sel.sv
// Registered N-channel display-source selector feeding the hex/7-seg driver.
// Supports manual select, auto-rotate, freeze and off, with a blanking gap on every channel change.
module disp_src_sel #(
  parameter int N_CH      = 4,
  parameter int W         = 32,
  parameter int SEL_W     = 2,
  parameter int DWELL     = 50_000_000,
  parameter int BLANK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] data_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_stb,
  input  logic [1:0]        mode,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  output logic              out_blank,
  output logic              sel_err
);

  localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int BC_W = $clog2(BLANK_CYC + 1);

  localparam logic [DW_W-1:0]  DWELL_TC  = DW_W'(DWELL - 1);
  localparam logic [BC_W-1:0]  BLANK_LD  = BC_W'(BLANK_CYC);
  localparam logic [BC_W-1:0]  BLANK_ONE = BC_W'(1);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_X    = (SEL_W + 1)'(N_CH);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BLANK  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_OFF    = 2'd3
  } state_t;

  state_t           state_r,     state_s;
  state_t           resume_r,    resume_s;
  state_t           cur_s;
  logic [SEL_W-1:0] target_r,    target_s;
  logic [BC_W-1:0]  blank_cnt_r, blank_cnt_s;
  logic [DW_W-1:0]  dwell_cnt_r, dwell_cnt_s;
  logic [W-1:0]     out_data_r,  out_data_s;
  logic [SEL_W-1:0] out_ch_r,    out_ch_s;
  logic             out_valid_r, out_valid_s;
  logic             out_blank_r, out_blank_s;
  logic             sel_err_r,   sel_err_s;

  logic             sel_ok_s;
  logic             req_s;
  logic             bad_s;
  logic [SEL_W-1:0] next_ch_s;

  function automatic logic [W-1:0] pick_word(input logic [N_CH*W-1:0] d,
                                             input logic [SEL_W-1:0]  c);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      r = (c == SEL_W'(k)) ? d[k*W +: W] : r;
    end
    return r;
  endfunction

  assign sel_ok_s  = ({1'b0, sel} < N_CH_X);
  assign req_s     = sel_stb & sel_ok_s;
  assign bad_s     = sel_stb & ~sel_ok_s;
  assign next_ch_s = (out_ch_r == LAST_CH) ? {SEL_W{1'b0}} : (out_ch_r + SEL_W'(1));
  // A frozen block resumes whatever RUN/BLANK state it was frozen in.
  assign cur_s     = (state_r == ST_FREEZE) ? resume_r : state_r;

  // Next-state and next-output logic; mode takes priority over sel_stb.
  always_comb begin
    state_s     = state_r;
    resume_s    = resume_r;
    target_s    = target_r;
    blank_cnt_s = blank_cnt_r;
    dwell_cnt_s = dwell_cnt_r;
    out_data_s  = out_data_r;
    out_ch_s    = out_ch_r;
    out_valid_s = out_valid_r;
    out_blank_s = out_blank_r;
    sel_err_s   = 1'b0;

    case (mode)
      MODE_OFF: begin
        state_s     = ST_OFF;
        out_data_s  = {W{1'b0}};
        out_valid_s = 1'b0;
        out_blank_s = 1'b1;
      end

      MODE_FREEZE: begin
        case (state_r)
          ST_FREEZE: begin
            state_s = ST_FREEZE;
          end
          ST_OFF: begin
            // Thawing from OFF must still produce a full gap on the retained channel.
            state_s     = ST_FREEZE;
            resume_s    = ST_BLANK;
            target_s    = out_ch_r;
            blank_cnt_s = BLANK_LD;
            dwell_cnt_s = {DW_W{1'b0}};
          end
          default: begin
            state_s  = ST_FREEZE;
            resume_s = state_r;
          end
        endcase
      end

      default: begin
        sel_err_s = bad_s;
        state_s   = cur_s;
        case (cur_s)
          ST_OFF: begin
            state_s     = ST_BLANK;
            target_s    = out_ch_r;
            blank_cnt_s = BLANK_LD;
            dwell_cnt_s = {DW_W{1'b0}};
          end

          ST_RUN: begin
            if (req_s) begin
              state_s     = ST_BLANK;
              target_s    = sel;
              blank_cnt_s = BLANK_LD;
              dwell_cnt_s = {DW_W{1'b0}};
              out_data_s  = {W{1'b0}};
              out_valid_s = 1'b0;
              out_blank_s = 1'b1;
            end else if ((mode == MODE_AUTO) && (dwell_cnt_r == DWELL_TC)) begin
              state_s     = ST_BLANK;
              target_s    = next_ch_s;
              blank_cnt_s = BLANK_LD;
              dwell_cnt_s = {DW_W{1'b0}};
              out_data_s  = {W{1'b0}};
              out_valid_s = 1'b0;
              out_blank_s = 1'b1;
            end else begin
              state_s     = ST_RUN;
              dwell_cnt_s = (mode == MODE_AUTO) ? (dwell_cnt_r + DW_W'(1)) : {DW_W{1'b0}};
              out_data_s  = pick_word(data_in, out_ch_r);
              out_valid_s = 1'b1;
              out_blank_s = 1'b0;
            end
          end

          ST_BLANK: begin
            if (req_s) begin
              state_s     = ST_BLANK;
              target_s    = sel;
              blank_cnt_s = BLANK_LD;
              dwell_cnt_s = {DW_W{1'b0}};
            end else if (blank_cnt_r == BLANK_ONE) begin
              state_s     = ST_RUN;
              out_ch_s    = target_r;
              out_data_s  = pick_word(data_in, target_r);
              out_valid_s = 1'b1;
              out_blank_s = 1'b0;
            end else begin
              state_s     = ST_BLANK;
              blank_cnt_s = blank_cnt_r - BC_W'(1);
            end
          end

          default: begin
            state_s     = ST_BLANK;
            target_s    = out_ch_r;
            blank_cnt_s = BLANK_LD;
          end
        endcase

        if (mode == MODE_MANUAL) begin
          dwell_cnt_s = {DW_W{1'b0}};
        end else begin
          dwell_cnt_s = dwell_cnt_s;
        end
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_BLANK;
      resume_r    <= ST_BLANK;
      target_r    <= {SEL_W{1'b0}};
      blank_cnt_r <= BLANK_LD;
      dwell_cnt_r <= {DW_W{1'b0}};
      out_data_r  <= {W{1'b0}};
      out_ch_r    <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
      out_blank_r <= 1'b1;
      sel_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      resume_r    <= resume_s;
      target_r    <= target_s;
      blank_cnt_r <= blank_cnt_s;
      dwell_cnt_r <= dwell_cnt_s;
      out_data_r  <= out_data_s;
      out_ch_r    <= out_ch_s;
      out_valid_r <= out_valid_s;
      out_blank_r <= out_blank_s;
      sel_err_r   <= sel_err_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;
  assign out_blank = out_blank_r;
  assign sel_err   = sel_err_r;

endmodule
